// File: rtl/stoch_decode.sv
// Windowed stochastic-to-binary decoder: counts 1s over 2^WINDOW_LOG2 valid samples
// and holds the result under a valid/ready handshake. Macro STOCH_DECODE_BIPOLAR_EN selects bipolar output.
module stoch_decode #(
  parameter int WINDOW_LOG2 = 8,
  parameter int OUT_WIDTH   = WINDOW_LOG2 + 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 a,
  output logic [OUT_WIDTH-1:0] y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 overrun
);

  logic [WINDOW_LOG2:0]   ones_q, ones_d, sum_p0;
  logic [WINDOW_LOG2-1:0] samp_q, samp_d;
  logic [OUT_WIDTH-1:0]   y_q, y_d;
  logic                   y_valid_q, y_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   close_p0;

  // Map a window count (0..2^WINDOW_LOG2) onto the output word.
  function automatic logic [OUT_WIDTH-1:0] window_result(input logic [WINDOW_LOG2:0] cnt);
`ifdef STOCH_DECODE_BIPOLAR_EN
    logic signed [OUT_WIDTH-1:0] dbl;
    logic signed [OUT_WIDTH-1:0] bias;
    dbl  = $signed({cnt, 1'b0});
    bias = $signed(OUT_WIDTH'(1) << WINDOW_LOG2);
    return dbl - bias;
`else
    return OUT_WIDTH'(cnt);
`endif
  endfunction

  // Stage p0: count, detect window close, run the output handshake.
  always_comb begin
    close_p0  = en && (samp_q == '1);
    sum_p0    = ones_q + (WINDOW_LOG2 + 1)'(a);
    ones_d    = ones_q;
    samp_d    = samp_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    overrun_d = overrun_q;
    if (en) begin
      samp_d = samp_q + WINDOW_LOG2'(1);
      ones_d = close_p0 ? '0 : sum_p0;
    end
    if (close_p0) begin
      y_d       = window_result(sum_p0);
      y_valid_d = 1'b1;
      if (y_valid_q && !y_ready) overrun_d = 1'b1;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ones_q    <= '0;
      samp_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ones_q    <= ones_d;
      samp_q    <= samp_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_stoch_decode.sv
// Bench for stoch_decode at WINDOW_LOG2=2: directed vector table plus a randomized run,
// with window results tracked through a scoreboard queue.
module tb_stoch_decode;

  localparam int W  = 2;
  localparam int OW = W + 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          en = 1'b0;
  logic          a = 1'b0;
  logic          y_ready = 1'b0;
  logic [OW-1:0] y;
  logic          y_valid;
  logic          overrun;

  stoch_decode #(.WINDOW_LOG2(W)) dut (
    .CLK(CLK), .RST(RST), .en(en), .a(a),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic r, e, av, rd;
    logic ev, eo;
    int   yk;   // 0: y not checked, 1: y = result of cnt, 2: y = 0 (reset)
    int   cnt;
  } vec_t;

  vec_t          vecs[$];
  logic [OW-1:0] exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            m_ones, m_samp;
  logic [OW-1:0] m_y;
  logic          m_valid, m_ovr;

  function automatic logic [OW-1:0] conv(input int c);
`ifdef STOCH_DECODE_BIPOLAR_EN
    return OW'(2 * c - (1 << W));
`else
    return OW'(c);
`endif
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, e, av, rd, ev, eo, input int yk, cnt);
    vec_t v;
    v.r = r; v.e = e; v.av = av; v.rd = rd; v.ev = ev; v.eo = eo; v.yk = yk; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic e, av, rd, ev, eo, input int yk, cnt);
    for (int i = 0; i < n; i++) add(1'b0, e, av, rd, ev, eo, yk, cnt);
  endtask

  // Drive one cycle, advance the reference model, then compare after the edge.
  task automatic step(input logic r, e, av, rd);
    logic          close;
    int            sum;
    logic [OW-1:0] ex;
    RST = r; en = e; a = av; y_ready = rd;
    close = 1'b0;
    if (r) begin
      m_ones = 0; m_samp = 0; m_y = '0; m_valid = 1'b0; m_ovr = 1'b0;
      exp_q.delete();
    end else begin
      close = e && (m_samp == (1 << W) - 1);
      sum   = m_ones + int'(av);
      if (close) begin
        exp_q.push_back(conv(sum));
        m_y = conv(sum);
        if (m_valid && !rd) m_ovr = 1'b1;
        m_valid = 1'b1;
      end else if (m_valid && rd) begin
        m_valid = 1'b0;
      end
      if (e) begin
        m_samp = (m_samp + 1) % (1 << W);
        m_ones = close ? 0 : sum;
      end
    end
    @(posedge CLK);
    #1;
    if (close) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL sb_empty: got result %0h expected none queued", y);
      end else begin
        ex = exp_q.pop_front();
        check("sb_y", y, ex);
      end
    end
    check("m_valid", OW'(y_valid), OW'(m_valid));
    check("m_overrun", OW'(overrun), OW'(m_ovr));
    if (m_valid) check("m_y_hold", y, m_y);
  endtask

  initial begin
    // reset
    add(1, 0, 0, 0, 0, 0, 2, 0);
    // all ones, accept one edge later
    add_n(3, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 1, 4);
    add(0, 0, 0, 1, 0, 0, 1, 4);
    // gapped sampling 1,0,1,0
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 1, 2);
    add(0, 0, 0, 1, 0, 0, 1, 2);
    // all zeros
    add_n(3, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0);
    // backpressure: window of 1s then 0s without accept
    add_n(3, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 4);
    add_n(3, 1, 0, 0, 1, 0, 1, 4);
    add(0, 1, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2, 0);
    // accept exactly on the second close
    add_n(3, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 4);
    add_n(3, 1, 0, 0, 1, 0, 1, 4);
    add(0, 1, 0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0);
    // reset mid-window with a result pending
    add_n(3, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 4);
    add_n(2, 1, 1, 0, 1, 0, 1, 4);
    add(1, 1, 1, 0, 0, 0, 2, 0);
    add_n(3, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 1, 4);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].e, vecs[i].av, vecs[i].rd);
      check($sformatf("v%0d_valid", i), OW'(y_valid), OW'(vecs[i].ev));
      check($sformatf("v%0d_overrun", i), OW'(overrun), OW'(vecs[i].eo));
      if (vecs[i].yk == 1) check($sformatf("v%0d_y", i), y, conv(vecs[i].cnt));
      else if (vecs[i].yk == 2) check($sformatf("v%0d_y_rst", i), y, '0);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
